// File: rtl/prbs31_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions for the serial generator and checker.
// Holds the tap positions, the checker state encoding and the feedback helper.
package prbs31_pkg;

  localparam int PRBS_W = 31;
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic prbs31_next(input logic [PRBS_W-1:0] s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

endpackage

// File: rtl/prbs31_checker_if.sv
// Serial bit stream into the PRBS31 checker and its lock/BER status outputs.
// No backpressure: the checker consumes every bit flagged by din_valid.
interface prbs31_checker_if #(
  parameter int CNT_W = 16
);
  logic             din;
  logic             din_valid;
  logic             clear_cnt;
  logic             locked;
  logic             err_pulse;
  logic             sync_loss;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output din, din_valid, clear_cnt,
    input  locked, err_pulse, sync_loss, err_count, bit_count
  );

  modport slave (
    input  din, din_valid, clear_cnt,
    output locked, err_pulse, sync_loss, err_count, bit_count
  );
endinterface

// File: rtl/prbs31_sync_fsm.sv
// Lock acquisition/loss FSM for the PRBS31 checker: seed, verify, locked with windowed error threshold.
// locked/sync_loss registered, one cycle after the deciding valid bit; never stalls its input.
module prbs31_sync_fsm
  import prbs31_pkg::*;
#(
  parameter int LOCK_CNT = 64,
  parameter int WIN_LEN  = 1024,
  parameter int LOSS_THR = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   bit_vld,
  input  logic   mismatch,
  input  logic   seed_nz,
  output state_t state,
  output logic   locked,
  output logic   sync_loss
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int ERR_W   = $clog2(LOSS_THR + 1);

  state_t             state_q, state_nxt;
  logic [4:0]         seed_q, seed_nxt;
  logic [MATCH_W-1:0] match_q, match_nxt;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_nxt;
  logic [ERR_W-1:0]   win_err_q, win_err_nxt;
  logic [ERR_W-1:0]   win_err_sum;
  logic               loss_nxt;
  logic               locked_q;
  logic               sync_loss_q;

  always_comb begin
    state_nxt   = state_q;
    seed_nxt    = seed_q;
    match_nxt   = match_q;
    win_cnt_nxt = win_cnt_q;
    win_err_nxt = win_err_q;
    loss_nxt    = 1'b0;
    // Errors on the wrap bit still count toward the window that is closing.
    win_err_sum = win_err_q + ERR_W'(mismatch);

    if (bit_vld) begin
      case (state_q)
        SEED: begin
          if (seed_q == 5'd30) begin
            seed_nxt = '0;
            if (seed_nz) begin
              state_nxt = VERIFY;
            end
          end else begin
            seed_nxt = seed_q + 5'd1;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            state_nxt = SEED;
            match_nxt = '0;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_nxt = LOCKED;
            match_nxt = '0;
          end else begin
            match_nxt = match_q + MATCH_W'(1);
          end
        end
        LOCKED: begin
          win_cnt_nxt = win_cnt_q + WIN_W'(1);
          if (win_err_sum >= ERR_W'(LOSS_THR)) begin
            state_nxt   = SEED;
            loss_nxt    = 1'b1;
            match_nxt   = '0;
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else if (win_cnt_q == WIN_W'(WIN_LEN - 1)) begin
            win_err_nxt = '0;
          end else begin
            win_err_nxt = win_err_sum;
          end
        end
        default: begin
          state_nxt = SEED;
        end
      endcase
    end
  end

  // rst_n is active-high in this codebase.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= SEED;
      seed_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      seed_q      <= seed_nxt;
      match_q     <= match_nxt;
      win_cnt_q   <= win_cnt_nxt;
      win_err_q   <= win_err_nxt;
      locked_q    <= (state_nxt == LOCKED);
      sync_loss_q <= loss_nxt;
    end
  end

  assign state     = state_q;
  assign locked    = locked_q;
  assign sync_loss = sync_loss_q;

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: self-syncs, locks, then counts bit errors; all status registered, 1-cycle latency.
// No backpressure on din. Optional bit counter for BER under PRBS_CHK_BITCNT_EN.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOCK_CNT = 64,
  parameter int WIN_LEN  = 1024,
  parameter int LOSS_THR = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  prbs31_checker_if.slave  bus
);

  logic [PRBS_W-1:0] s_q;
  logic              pred;
  logic              mismatch;
  logic              seed_nz;
  logic              err_hit;
  logic              in_lock;
  state_t            state;
  logic              fsm_locked;
  logic              fsm_sync_loss;
  logic              err_pulse_q;
  logic [CNT_W-1:0]  err_cnt_q;

  assign pred     = prbs31_next(s_q);
  assign mismatch = bus.din ^ pred;
  assign seed_nz  = ({s_q[PRBS_W-2:0], bus.din} != '0);
  assign in_lock  = (state == LOCKED);
  assign err_hit  = bus.din_valid & in_lock & mismatch;

  prbs31_sync_fsm #(
    .LOCK_CNT (LOCK_CNT),
    .WIN_LEN  (WIN_LEN),
    .LOSS_THR (LOSS_THR)
  ) u_sync_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_vld   (bus.din_valid),
    .mismatch  (mismatch),
    .seed_nz   (seed_nz),
    .state     (state),
    .locked    (fsm_locked),
    .sync_loss (fsm_sync_loss)
  );

  // Once locked the reference free-runs, so a line error never enters s.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s_q <= '0;
    end else if (bus.din_valid) begin
      s_q <= {s_q[PRBS_W-2:0], (in_lock ? pred : bus.din)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_hit;
      if (bus.clear_cnt) begin
        err_cnt_q <= '0;
      end else if (err_hit && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      bit_cnt_q <= '0;
    end else if (bus.clear_cnt) begin
      bit_cnt_q <= '0;
    end else if (bus.din_valid && in_lock && (bit_cnt_q != '1)) begin
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  assign bus.bit_count = bit_cnt_q;
`else
  assign bus.bit_count = '0;
`endif

  assign bus.locked    = fsm_locked;
  assign bus.sync_loss = fsm_sync_loss;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: lock, single/burst errors, resync, gaps, clear and saturation.
// A 16-bit and a 4-bit counter instance share one stimulus stream.
`timescale 1ns/1ps
module tb_prbs31_checker;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  prbs31_checker_if #(.CNT_W(16)) bus ();
  prbs31_checker_if #(.CNT_W(4))  bus4 ();

  assign bus4.din       = bus.din;
  assign bus4.din_valid = bus.din_valid;
  assign bus4.clear_cnt = bus.clear_cnt;

  prbs31_checker #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  prbs31_checker #(.CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int          total = 0;
  int          bad   = 0;
  logic [30:0] g;
  logic        exp_q[$];
  int          vbits;
  int          lock_at;
  logic        lock_seen;
  logic        unlock_seen;
  int          pulse_cnt;
  int          sl_cnt;
  logic [31:0] exp_bc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic track_reset();
    vbits       = 0;
    lock_at     = -1;
    lock_seen   = 1'b0;
    unlock_seen = 1'b0;
    pulse_cnt   = 0;
    sl_cnt      = 0;
  endtask

  // Expected err_pulse is pushed with the bit and popped once the DUT has sampled it.
  task automatic drive(input logic b, input logic v, input logic inv, input logic clr);
    logic e;
    @(negedge clk);
    bus.din       = b;
    bus.din_valid = v;
    bus.clear_cnt = clr;
    exp_q.push_back(v & inv);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("err_pulse", {31'd0, bus.err_pulse}, {31'd0, e});
    if (v) vbits++;
    if (bus.err_pulse) pulse_cnt++;
    if (bus.sync_loss) sl_cnt++;
    if (bus.locked && !lock_seen) begin
      lock_seen = 1'b1;
      lock_at   = vbits;
    end
    if (!bus.locked) unlock_seen = 1'b1;
  endtask

  task automatic step(input logic inv, input logic v, input logic clr);
    logic b;
    if (v) begin
      b = g[30];
      g = {g[29:0], g[30] ^ g[27]};
    end else begin
      b = 1'($urandom);
    end
    drive(b ^ (inv & v), v, inv, clr);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.din_valid = 1'b0;
    bus.clear_cnt = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.din       = 1'($urandom);
      bus.din_valid = 1'($urandom);
    end
    #1;
    rst_n         = 1'b0;
    bus.din_valid = 1'b0;
    track_reset();
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.clear_cnt = 1'b0;
`ifdef PRBS_CHK_BITCNT_EN
    exp_bc = 32'd9905;
`else
    exp_bc = 32'd0;
`endif

    // 1. reset state
    do_reset(2);
    chk("rst_locked",    {31'd0, bus.locked},    32'd0);
    chk("rst_err_pulse", {31'd0, bus.err_pulse}, 32'd0);
    chk("rst_sync_loss", {31'd0, bus.sync_loss}, 32'd0);
    chk("rst_err_count", {16'd0, bus.err_count}, 32'd0);
    chk("rst_bit_count", {16'd0, bus.bit_count}, 32'd0);

    // 2. clean stream from seed 1
    g = 31'd1;
    for (int i = 1; i <= 10000; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 94) chk("lock_before_95", {31'd0, bus.locked}, 32'd0);
      if (i == 95) chk("lock_at_95", {31'd0, bus.locked}, 32'd1);
    end
    chk("lock_point",       lock_at, 32'd95);
    chk("clean_err_count",  {16'd0, bus.err_count}, 32'd0);
    chk("clean_bit_count",  {16'd0, bus.bit_count}, exp_bc);
    chk("clean_sync_loss",  sl_cnt, 32'd0);

    // 3. single inverted bit
    track_reset();
    for (int i = 1; i <= 1000; i++) step(i == 500, 1'b1, 1'b0);
    chk("single_pulses",    pulse_cnt, 32'd1);
    chk("single_err_count", {16'd0, bus.err_count}, 32'd1);
    chk("single_unlock",    {31'd0, unlock_seen}, 32'd0);

    // 4. sixteen errors in one fresh window -> loss and relock
    step(1'b0, 1'b1, 1'b1);
    chk("clear_err_count", {16'd0, bus.err_count}, 32'd0);
    for (int i = 0; i < 400; i++) step(1'b0, 1'b1, 1'b0);
    track_reset();
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    chk("loss_pulse_now",   {31'd0, bus.sync_loss}, 32'd1);
    chk("loss_locked",      {31'd0, bus.locked},    32'd0);
    chk("loss_pulse_count", sl_cnt, 32'd1);
    track_reset();
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0);
    chk("relock_point",   lock_at, 32'd95);
    chk("loss_err_count", {16'd0, bus.err_count}, 32'd16);
    chk("relock_no_loss", sl_cnt, 32'd0);

    // 5. reset mid-operation with din_valid low, all-zero stream, valid gaps
    do_reset(1);
    chk("midrst_locked",    {31'd0, bus.locked},    32'd0);
    chk("midrst_err_count", {16'd0, bus.err_count}, 32'd0);
    for (int i = 0; i < 5000; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zeros_never_lock", {31'd0, lock_seen}, 32'd0);
    do_reset(2);
    g = 31'd1;
    for (int i = 0; i < 400; i++) step(1'b0, ($urandom_range(0, 2) != 0), 1'b0);
    chk("gap_lock_point", lock_at, 32'd95);
    chk("gap_locked",     {31'd0, bus.locked}, 32'd1);

    // 6. clear coincident with error, then saturation on the 4-bit instance
    step(1'b1, 1'b1, 1'b1);
    chk("clr_err_same_cycle", {16'd0, bus.err_count}, 32'd0);
    chk("clr_keeps_lock",     {31'd0, bus.locked},    32'd1);
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 99; j++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    chk("sat16_err_count", {16'd0, bus.err_count},  32'd20);
    chk("sat4_err_count",  {28'd0, bus4.err_count}, 32'd15);
    chk("sat4_locked",     {31'd0, bus4.locked},    32'd1);
`ifdef PRBS_CHK_BITCNT_EN
    exp_bc = 32'd2000;
`endif
    chk("sat_bit_count", {16'd0, bus.bit_count}, exp_bc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
